// File: rtl/ex_mem_skid_buff_pkg.sv
// ex_mem_skid_buff_pkg: default field widths and the packed EX/MEM payload layout.
// Revision: 1.0
`default_nettype none

package ex_mem_skid_buff_pkg;

  localparam int WB_SIZE   = 4;
  localparam int MEM_SIZE  = 6;
  localparam int FLAG_SIZE = 4;
  localparam int DATA_W    = 16;
  localparam int PC_W      = 32;
  localparam int RDST_W    = 3;

  // Field order matches the flattened vector used inside the buffer (WB at the MSBs).
  typedef struct packed {
    logic [WB_SIZE-1:0]   wb;
    logic [MEM_SIZE-1:0]  mem;
    logic [PC_W-1:0]      pc;
    logic [RDST_W-1:0]    rdst;
    logic [DATA_W-1:0]    alu;
    logic [DATA_W-1:0]    read_data1;
    logic [FLAG_SIZE-1:0] flag;
  } ex_mem_payload_t;

  localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

endpackage

`default_nettype wire

// File: rtl/ex_mem_skid_buff_pipe_entry_reg.sv
// pipe_entry_reg: one payload register with valid bit; kill beats load beats clear.
// Revision: 1.0
`default_nettype none

module pipe_entry_reg #(
  parameter int           W         = 8,
  parameter logic [W-1:0] KILL_MASK = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_clear,
  input  logic         i_kill,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Kill zeroes the masked control bits so a dropped entry cannot trigger writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
      r_data  <= r_data & ~KILL_MASK;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/ex_mem_skid_buff.sv
// ex_mem_skid_buff: two-entry EX/MEM skid buffer with registered ready and flush.
// Optional stall counter on o_stall_cnt when EX_MEM_STALL_CNT_EN is defined.  Revision: 1.0
`default_nettype none

module ex_mem_skid_buff
  import ex_mem_skid_buff_pkg::*;
#(
  parameter int WB_SIZE   = ex_mem_skid_buff_pkg::WB_SIZE,
  parameter int MEM_SIZE  = ex_mem_skid_buff_pkg::MEM_SIZE,
  parameter int FLAG_SIZE = ex_mem_skid_buff_pkg::FLAG_SIZE,
  parameter int DATA_W    = ex_mem_skid_buff_pkg::DATA_W,
  parameter int PC_W      = ex_mem_skid_buff_pkg::PC_W,
  parameter int RDST_W    = ex_mem_skid_buff_pkg::RDST_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_flush,
  input  logic [WB_SIZE-1:0]   i_WB,
  input  logic [MEM_SIZE-1:0]  i_Mem,
  input  logic [PC_W-1:0]      i_pc,
  input  logic [RDST_W-1:0]    i_Rdst,
  input  logic [DATA_W-1:0]    i_alu,
  input  logic [DATA_W-1:0]    i_read_data1,
  input  logic [FLAG_SIZE-1:0] i_flag,
  output logic                 o_valid,
  input  logic                 i_ready,
`ifdef EX_MEM_STALL_CNT_EN
  output logic [15:0]          o_stall_cnt,
`endif
  output logic [WB_SIZE-1:0]   o_WB,
  output logic [MEM_SIZE-1:0]  o_Mem,
  output logic [PC_W-1:0]      o_pc,
  output logic [RDST_W-1:0]    o_Rdst,
  output logic [DATA_W-1:0]    o_alu,
  output logic [DATA_W-1:0]    o_read_data1,
  output logic [FLAG_SIZE-1:0] o_flag
);

  localparam int c_pay_w  = WB_SIZE + MEM_SIZE + PC_W + RDST_W + 2*DATA_W + FLAG_SIZE;
  localparam int c_ctl_w  = WB_SIZE + MEM_SIZE;
  localparam logic [c_pay_w-1:0] c_kill_mask = {{c_ctl_w{1'b1}}, {(c_pay_w-c_ctl_w){1'b0}}};

  logic [c_pay_w-1:0] w_in_data;
  logic [c_pay_w-1:0] w_main_data;
  logic [c_pay_w-1:0] w_skid_data;
  logic [c_pay_w-1:0] w_main_next;
  logic               w_main_valid;
  logic               w_skid_valid;
  logic               w_accept;
  logic               w_xfer;
  logic               w_main_load;
  logic               w_main_clear;
  logic               w_skid_load;
  logic               w_skid_clear;

  assign w_in_data = {i_WB, i_Mem, i_pc, i_Rdst, i_alu, i_read_data1, i_flag};

  assign o_ready  = ~w_skid_valid;
  assign o_valid  = w_main_valid;
  assign w_accept = i_valid & o_ready & ~i_flush;
  assign w_xfer   = w_main_valid & i_ready;

  // A valid skid always refills main on transfer; o_ready is low so no input competes.
  assign w_main_next  = w_skid_valid ? w_skid_data : w_in_data;
  assign w_main_load  = (w_xfer & w_skid_valid) | (w_accept & (~w_main_valid | w_xfer));
  assign w_main_clear = w_xfer & ~w_main_load;
  assign w_skid_load  = w_accept & w_main_valid & ~w_xfer;
  assign w_skid_clear = w_xfer & w_skid_valid;

  pipe_entry_reg #(
    .W         (c_pay_w),
    .KILL_MASK (c_kill_mask)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_data  (w_main_next),
    .i_clear (w_main_clear),
    .i_kill  (i_flush),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  pipe_entry_reg #(
    .W         (c_pay_w),
    .KILL_MASK (c_kill_mask)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_data  (w_in_data),
    .i_clear (w_skid_clear),
    .i_kill  (i_flush),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign {o_WB, o_Mem, o_pc, o_Rdst, o_alu, o_read_data1, o_flag} = w_main_data;

`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Flush does not clear the counter; only reset does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_main_valid && !i_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
